// File: rtl/core_clk_rst_seq_if.sv
// Request/status bundle between the system control register block and one
// clock/reset sequencer instance.
interface core_clk_rst_seq_if;
   logic       clk_en_req_i;
   logic       rst_n_req_i;
   logic       pll_locked_i;
   logic       core_clk_en_o;
   logic       core_rst_no;
   logic       busy_o;
   logic       lock_err_o;
   logic [2:0] state_o;

   modport master (
      output clk_en_req_i, rst_n_req_i, pll_locked_i,
      input  core_clk_en_o, core_rst_no, busy_o, lock_err_o, state_o
   );

   modport slave (
      input  clk_en_req_i, rst_n_req_i, pll_locked_i,
      output core_clk_en_o, core_rst_no, busy_o, lock_err_o, state_o
   );
endinterface

// File: rtl/core_clk_rst_seq.sv
// Orders clock-gate enable and reset release for one core/link domain:
// clock only after PLL lock, reset release only after settle, gate only after drain.
module core_clk_rst_seq #(
   parameter int unsigned CLK_SETTLE_CYCLES   = 8,
   parameter int unsigned RST_DRAIN_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 1024
) (
   input  logic               clk_i,
   input  logic               srst_i,
   core_clk_rst_seq_if.slave  bus
);
   localparam int unsigned MAX_SD    = (CLK_SETTLE_CYCLES > RST_DRAIN_CYCLES) ?
                                       CLK_SETTLE_CYCLES : RST_DRAIN_CYCLES;
   localparam int unsigned MAX_ALL   = (MAX_SD > LOCK_TIMEOUT_CYCLES) ?
                                       MAX_SD : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned CNT_WIDTH = $clog2(MAX_ALL) + 1;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_CLK_ON    = 3'd3,
      ST_RUN       = 3'd4,
      ST_DRAIN     = 3'd5,
      ST_ERR       = 3'd6,
      ST_UNUSED    = 3'd7
   } state_t;

   state_t               r_state;
   state_t               w_nxt_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_clk_en;
   logic                 r_rst_n;
   logic                 r_busy;
   logic                 r_lock_err;
   logic                 w_stop;
   logic                 w_timed;
   logic                 w_lock_tmo;
   logic                 w_settle_done;
   logic                 w_drain_done;

   // Any loss of request or lock while the clock runs forces the drain path.
   assign w_stop        = !bus.clk_en_req_i || !bus.pll_locked_i;
   assign w_timed       = (r_state == ST_WAIT_LOCK) || (r_state == ST_SETTLE) ||
                          (r_state == ST_DRAIN);
   assign w_lock_tmo    = (r_cnt == CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1));
   assign w_settle_done = (r_cnt == CNT_WIDTH'(CLK_SETTLE_CYCLES - 1));
   assign w_drain_done  = (r_cnt == CNT_WIDTH'(RST_DRAIN_CYCLES - 1));

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         ST_OFF: begin
            if (bus.clk_en_req_i) w_nxt_state = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (!bus.clk_en_req_i)     w_nxt_state = ST_OFF;
            else if (bus.pll_locked_i) w_nxt_state = ST_SETTLE;
            else if (w_lock_tmo)       w_nxt_state = ST_ERR;
         end
         ST_SETTLE: begin
            if (w_stop)             w_nxt_state = ST_DRAIN;
            else if (w_settle_done) w_nxt_state = ST_CLK_ON;
         end
         ST_CLK_ON: begin
            if (w_stop)               w_nxt_state = ST_DRAIN;
            else if (bus.rst_n_req_i) w_nxt_state = ST_RUN;
         end
         ST_RUN: begin
            if (w_stop)                w_nxt_state = ST_DRAIN;
            else if (!bus.rst_n_req_i) w_nxt_state = ST_CLK_ON;
         end
         ST_DRAIN: begin
            if (w_drain_done) w_nxt_state = ST_OFF;
         end
         ST_ERR: begin
            if (!bus.clk_en_req_i) w_nxt_state = ST_OFF;
         end
         default: w_nxt_state = ST_OFF;
      endcase
   end

   // Outputs are registered from the next state, so they always equal the
   // Moore decode of the state register.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state    <= ST_OFF;
         r_cnt      <= '0;
         r_clk_en   <= 1'b0;
         r_rst_n    <= 1'b0;
         r_busy     <= 1'b0;
         r_lock_err <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         if (w_nxt_state != r_state) r_cnt <= '0;
         else if (w_timed)           r_cnt <= r_cnt + CNT_WIDTH'(1);
         r_clk_en   <= (w_nxt_state == ST_SETTLE) || (w_nxt_state == ST_CLK_ON) ||
                       (w_nxt_state == ST_RUN)    || (w_nxt_state == ST_DRAIN);
         r_rst_n    <= (w_nxt_state == ST_RUN);
         r_busy     <= (w_nxt_state == ST_WAIT_LOCK) || (w_nxt_state == ST_SETTLE) ||
                       (w_nxt_state == ST_DRAIN);
         r_lock_err <= (w_nxt_state == ST_ERR);
      end
   end

   assign bus.core_clk_en_o = r_clk_en;
   assign bus.core_rst_no   = r_rst_n;
   assign bus.busy_o        = r_busy;
   assign bus.lock_err_o    = r_lock_err;
   assign bus.state_o       = r_state;
endmodule

// File: tb/tb_core_clk_rst_seq.sv
// Self-checking bench for core_clk_rst_seq: directed scenarios plus randomized
// requests compared each cycle against a countdown-based reference model.
module tb_core_clk_rst_seq;
   localparam int unsigned SETTLE = 8;
   localparam int unsigned DRAIN  = 16;
   localparam int unsigned TMO    = 1024;

   localparam int S_OFF = 0, S_WAIT = 1, S_SETTLE = 2, S_CLKON = 3,
                  S_RUN = 4, S_DRAIN = 5, S_ERR = 6;

   logic clk = 1'b0;
   logic srst = 1'b1;
   logic en = 1'b0, rn = 1'b0, lk = 1'b0;
   logic mon_en = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int m_state = S_OFF;
   int m_left  = 0;

   core_clk_rst_seq_if bus ();

   assign bus.clk_en_req_i = en;
   assign bus.rst_n_req_i  = rn;
   assign bus.pll_locked_i = lk;

   core_clk_rst_seq #(
      .CLK_SETTLE_CYCLES  (SETTLE),
      .RST_DRAIN_CYCLES   (DRAIN),
      .LOCK_TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i (clk),
      .srst_i(srst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: each timed phase holds a "cycles left" budget.
   task automatic enter(input int s, input int len);
      m_state = s;
      m_left  = len;
   endtask

   task automatic model_step();
      if (srst) begin
         enter(S_OFF, 0);
         return;
      end
      case (m_state)
         S_OFF:    if (en) enter(S_WAIT, TMO);
         S_WAIT:   if (!en) enter(S_OFF, 0);
                   else if (lk) enter(S_SETTLE, SETTLE);
                   else if (m_left == 1) enter(S_ERR, 0);
                   else m_left--;
         S_SETTLE: if (!en || !lk) enter(S_DRAIN, DRAIN);
                   else if (m_left == 1) enter(S_CLKON, 0);
                   else m_left--;
         S_CLKON:  if (!en || !lk) enter(S_DRAIN, DRAIN);
                   else if (rn) enter(S_RUN, 0);
         S_RUN:    if (!en || !lk) enter(S_DRAIN, DRAIN);
                   else if (!rn) enter(S_CLKON, 0);
         S_DRAIN:  if (m_left == 1) enter(S_OFF, 0);
                   else m_left--;
         S_ERR:    if (!en) enter(S_OFF, 0);
         default:  enter(S_OFF, 0);
      endcase
   endtask

   function automatic logic [6:0] exp_vec();
      logic c, r, b, e;
      c = (m_state inside {S_SETTLE, S_CLKON, S_RUN, S_DRAIN});
      r = (m_state == S_RUN);
      b = (m_state inside {S_WAIT, S_SETTLE, S_DRAIN});
      e = (m_state == S_ERR);
      return {3'(m_state), c, r, b, e};
   endfunction

   function automatic logic [6:0] obs();
      return {bus.state_o, bus.core_clk_en_o, bus.core_rst_no, bus.busy_o, bus.lock_err_o};
   endfunction

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Ordering invariants watched on every cycle.
   int   low_run = 0;
   logic prev_clk = 1'b0;
   always @(posedge clk) begin
      logic s_at_edge;
      s_at_edge = srst;
      #1;
      if (mon_en) begin
         n_cmp++;
         if (bus.core_rst_no === 1'b1 &&
             !(bus.core_clk_en_o === 1'b1 && bus.state_o === 3'd4)) begin
            n_bad++;
            $display("FAIL inv_rst_release clk_en=%b state=%0d want clk_en=1 state=4",
                     bus.core_clk_en_o, bus.state_o);
         end
         if (prev_clk === 1'b1 && bus.core_clk_en_o === 1'b0 && !s_at_edge) begin
            n_cmp++;
            if (low_run < int'(DRAIN)) begin
               n_bad++;
               $display("FAIL inv_gate_after_drain rst_low_cycles=%0d want>=%0d", low_run, DRAIN);
            end
         end
         low_run  = (bus.core_rst_no === 1'b0) ? low_run + 1 : 0;
         prev_clk = bus.core_clk_en_o;
      end
   end

   task automatic test_reset();
      srst = 1'b1; en = 1'b0; rn = 1'b0; lk = 1'b0;
      step(); step();
      n_cmp++;
      if (obs() !== 7'd0) begin
         n_bad++; $display("FAIL reset_values got=%b want=%b", obs(), 7'd0);
      end
      en = 1'b1; rn = 1'b1; lk = 1'b1;
      step();
      n_cmp++;
      if (obs() !== 7'd0) begin
         n_bad++; $display("FAIL reset_overrides got=%b want=%b", obs(), 7'd0);
      end
      srst = 1'b0; en = 1'b0; rn = 1'b0; lk = 1'b0;
      step();
      mon_en = 1'b1;
   endtask

   task automatic go_to_run(input string tag);
      bit reached;
      reached = 1'b0;
      en = 1'b1; rn = 1'b1; lk = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL %s_cyc%0d got=%b want=%b", tag, i, obs(), exp_vec());
         end
         if (bus.state_o === 3'd4 && m_state == S_RUN) begin
            reached = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!reached) begin
         n_bad++; $display("FAIL %s_timeout state=%0d want=4", tag, bus.state_o);
      end
   endtask

   task automatic test_power_up();
      int t, clk_rise, rst_rise;
      srst = 1'b1; step(); srst = 1'b0;
      en = 1'b1; rn = 1'b1; lk = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL pu_prelock%0d got=%b want=%b", i, obs(), exp_vec());
         end
      end
      lk = 1'b1;
      clk_rise = -1; rst_rise = -1;
      for (t = 1; t <= 40; t++) begin
         step();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL pu_cyc%0d got=%b want=%b", t, obs(), exp_vec());
         end
         if (bus.core_clk_en_o === 1'b1 && clk_rise < 0) clk_rise = t;
         if (bus.core_rst_no === 1'b1 && rst_rise < 0) begin
            rst_rise = t;
            break;
         end
      end
      n_cmp++;
      if (clk_rise != 1) begin
         n_bad++; $display("FAIL pu_clk_en_latency got=%0d want=1", clk_rise);
      end
      // Settle window followed by one CLK_ON cycle before RUN.
      n_cmp++;
      if (rst_rise - clk_rise != int'(SETTLE) + 1) begin
         n_bad++; $display("FAIL pu_rst_latency got=%0d want=%0d", rst_rise - clk_rise, SETTLE + 1);
      end
      n_cmp++;
      if (bus.state_o !== 3'd4) begin
         n_bad++; $display("FAIL pu_final_state got=%0d want=4", bus.state_o);
      end
   endtask

   task automatic test_power_down();
      int cnt;
      en = 1'b0;
      step();
      n_cmp++;
      if ({bus.core_clk_en_o, bus.core_rst_no} !== 2'b10 || obs() !== exp_vec()) begin
         n_bad++; $display("FAIL pd_first got=%b want=%b", obs(), exp_vec());
      end
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         cnt++;
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL pd_cyc%0d got=%b want=%b", i, obs(), exp_vec());
         end
         if (bus.core_clk_en_o === 1'b0) break;
      end
      n_cmp++;
      if (cnt != int'(DRAIN)) begin
         n_bad++; $display("FAIL pd_drain_len got=%0d want=%0d", cnt, DRAIN);
      end
      n_cmp++;
      if (bus.state_o !== 3'd0) begin
         n_bad++; $display("FAIL pd_final_state got=%0d want=0", bus.state_o);
      end
   endtask

   task automatic test_lock_timeout();
      int err_at;
      en = 1'b1; rn = 1'b0; lk = 1'b0;
      err_at = -1;
      for (int i = 1; i <= int'(TMO) + 5; i++) begin
         step();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL tmo_cyc%0d got=%b want=%b", i, obs(), exp_vec());
         end
         if (bus.lock_err_o === 1'b1 && err_at < 0) err_at = i;
      end
      n_cmp++;
      if (err_at != int'(TMO) + 1) begin
         n_bad++; $display("FAIL tmo_err_edge got=%0d want=%0d", err_at, TMO + 1);
      end
      lk = 1'b1; rn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (obs() !== {3'd6, 4'b0001}) begin
            n_bad++; $display("FAIL tmo_sticky%0d got=%b want=%b", i, obs(), {3'd6, 4'b0001});
         end
      end
      en = 1'b0;
      step();
      n_cmp++;
      if (obs() !== 7'd0) begin
         n_bad++; $display("FAIL tmo_clear got=%b want=%b", obs(), 7'd0);
      end
   endtask

   task automatic test_lock_loss();
      int n_drain;
      bit saw_off, saw_wait, back;
      go_to_run("ll_setup");
      lk = 1'b0;
      step();
      lk = 1'b1;
      n_drain = 0; saw_off = 0; saw_wait = 0; back = 0;
      if (bus.state_o === 3'd5) n_drain++;
      n_cmp++;
      if (obs() !== exp_vec()) begin
         n_bad++; $display("FAIL ll_first got=%b want=%b", obs(), exp_vec());
      end
      for (int i = 0; i < 60; i++) begin
         step();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL ll_cyc%0d got=%b want=%b", i, obs(), exp_vec());
         end
         if (bus.state_o === 3'd5) n_drain++;
         if (bus.state_o === 3'd0) saw_off = 1;
         if (bus.state_o === 3'd1 && saw_off) saw_wait = 1;
         if (bus.state_o === 3'd4) begin back = 1; break; end
      end
      n_cmp++;
      if (n_drain != int'(DRAIN) || !saw_off || !saw_wait || !back) begin
         n_bad++;
         $display("FAIL ll_sequence drain=%0d off=%0d wait=%0d run=%0d want %0d/1/1/1",
                  n_drain, saw_off, saw_wait, back, DRAIN);
      end
   endtask

   task automatic test_rst_toggle();
      rn = 1'b0;
      step();
      n_cmp++;
      if (bus.state_o !== 3'd3 || bus.core_clk_en_o !== 1'b1 || bus.core_rst_no !== 1'b0) begin
         n_bad++; $display("FAIL rt_clk_on got=%b want state=3 clk=1 rst=0", obs());
      end
      rn = 1'b1;
      step();
      n_cmp++;
      if (obs() !== {3'd4, 4'b1100} || obs() !== exp_vec()) begin
         n_bad++; $display("FAIL rt_run got=%b want=%b", obs(), {3'd4, 4'b1100});
      end
   endtask

   task automatic test_mid_srst();
      int clk_rise, rst_rise;
      en = 1'b0; step();
      for (int i = 0; i < 40 && bus.state_o !== 3'd0; i++) step();
      en = 1'b1; rn = 1'b1; lk = 1'b1;
      for (int i = 0; i < 5; i++) step();
      // Five edges: OFF->WAIT, ->SETTLE, then three counting cycles.
      n_cmp++;
      if (bus.state_o !== 3'd2 || obs() !== exp_vec()) begin
         n_bad++; $display("FAIL ms_in_settle got=%b want=%b", obs(), exp_vec());
      end
      srst = 1'b1;
      step();
      srst = 1'b0;
      n_cmp++;
      if (obs() !== 7'd0) begin
         n_bad++; $display("FAIL ms_abort got=%b want=%b", obs(), 7'd0);
      end
      clk_rise = -1; rst_rise = -1;
      for (int t = 1; t <= 40; t++) begin
         step();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL ms_cyc%0d got=%b want=%b", t, obs(), exp_vec());
         end
         if (bus.core_clk_en_o === 1'b1 && clk_rise < 0) clk_rise = t;
         if (bus.core_rst_no === 1'b1) begin rst_rise = t; break; end
      end
      n_cmp++;
      if (clk_rise != 2 || rst_rise != 2 + int'(SETTLE) + 1) begin
         n_bad++; $display("FAIL ms_restart clk_rise=%0d rst_rise=%0d want 2/%0d",
                           clk_rise, rst_rise, 2 + SETTLE + 1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         srst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 9) == 0)  rn = ~rn;
         if ($urandom_range(0, 59) == 0) lk = ~lk;
         step();
         n_cmp++;
         if (obs() !== exp_vec()) begin
            n_bad++; $display("FAIL rnd_cyc%0d got=%b want=%b", i, obs(), exp_vec());
         end
      end
      srst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_power_down();
      test_lock_timeout();
      go_to_run("rt_setup");
      test_rst_toggle();
      test_lock_loss();
      test_mid_srst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
